// File: rtl/vending_pkg.sv
// vending_pkg: display codes, FSM states and the display-code helper shared by vending_ctrl
package vending_pkg;
    localparam logic [3:0] DISP_E = 4'b0110;
    localparam logic [3:0] DISP_N = 4'b1000;
    localparam logic [3:0] DISP_P = 4'b1001;
    typedef enum logic [1:0] {IDLE, SHOW_P, SHOW_N, SHOW_E} state_t;
    function automatic logic [3:0] disp_code(state_t s, logic [2:0] credit);
        return s == SHOW_P ? DISP_P : s == SHOW_N ? DISP_N : s == SHOW_E ? DISP_E : {1'b0, credit};
    endfunction
endpackage

// File: rtl/vending_ctrl_msg_timer.sv
// msg_timer: loadable down-counter that holds at zero and flags done there
module msg_timer #(
    parameter int MSG_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);
    localparam int TW = $clog2(MSG_CYCLES + 1);
    logic [TW-1:0] count;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else count <= load ? TW'(MSG_CYCLES - 1) : done ? count : count - TW'(1);
    assign done = count == '0;
endmodule

// File: rtl/vending_ctrl.sv
// vending_ctrl: credit tracking, buy/cancel handling and registered display/pulse outputs
module vending_ctrl
    import vending_pkg::*;
#(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 5,
    parameter int MSG_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_1,
    input  logic       coin_2,
    input  logic       buy,
    input  logic       cancel,
    output logic [3:0] codigo,
    output logic       dispense,
    output logic [2:0] change,
    output logic       change_valid,
    output logic       coin_reject,
    output logic       busy
);
    localparam logic [2:0] PRICE_C = 3'(PRICE);
    localparam logic [3:0] MAX_C   = 4'(MAX_CREDIT);
    state_t     state, nxt_state;
    logic [2:0] credit, nxt_credit, nxt_change;
    logic       nxt_dispense, nxt_cv, nxt_rej, coin, done, load;
    logic [3:0] add, sum;
    assign coin = coin_1 | coin_2;
    assign add  = {3'b0, coin_1} + {2'b0, coin_2, 1'b0};
    assign sum  = {1'b0, credit} + add;
    assign load = state == IDLE && nxt_state != IDLE;
    msg_timer #(.MSG_CYCLES(MSG_CYCLES)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .done (done)
    );
    // Coins are rejected by default; only an accepted IDLE deposit clears it
    always_comb begin
        nxt_state    = state;
        nxt_credit   = credit;
        nxt_dispense = 1'b0;
        nxt_change   = '0;
        nxt_cv       = 1'b0;
        nxt_rej      = coin;
        if (cancel) begin
            nxt_state  = IDLE;
            nxt_credit = '0;
            nxt_change = credit;
            nxt_cv     = credit != '0;
        end else if (state != IDLE) begin
            nxt_state = done ? IDLE : state;
        end else if (buy) begin
            nxt_state = credit >= PRICE_C ? SHOW_P : SHOW_N;
            if (credit >= PRICE_C) begin
                nxt_dispense = 1'b1;
                nxt_change   = credit - PRICE_C;
                nxt_cv       = nxt_change != '0;
                nxt_credit   = '0;
            end
        end else if (coin) begin
            nxt_rej    = sum > MAX_C;
            nxt_state  = sum > MAX_C ? SHOW_E : IDLE;
            nxt_credit = sum > MAX_C ? credit : sum[2:0];
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= IDLE;
            credit       <= '0;
            codigo       <= '0;
            dispense     <= 1'b0;
            change       <= '0;
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= nxt_state;
            credit       <= nxt_credit;
            codigo       <= disp_code(nxt_state, nxt_credit);
            dispense     <= nxt_dispense;
            change       <= nxt_change;
            change_valid <= nxt_cv;
            coin_reject  <= nxt_rej;
            busy         <= nxt_state != IDLE;
        end
endmodule

// File: tb/tb_vending_ctrl.sv
// tb_vending_ctrl: directed stimulus, per-cycle model comparison and literal spot checks
module tb_vending_ctrl;
    localparam int PRICE = 3, MAX_CREDIT = 5, MSG = 4;
    logic clk = 0, rst_n = 1, coin_1 = 0, coin_2 = 0, buy = 0, cancel = 0;
    logic [3:0] codigo;
    logic [2:0] change;
    logic dispense, change_valid, coin_reject, busy;
    int checks = 0, errors = 0;
    int m_credit = 0, m_left = 0, e_dispense = 0, e_change = 0, e_cv = 0, e_rej = 0;
    logic [3:0] m_msg = 0;

    vending_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .MSG_CYCLES(MSG)) dut (
        .clk(clk), .rst_n(rst_n), .coin_1(coin_1), .coin_2(coin_2), .buy(buy), .cancel(cancel),
        .codigo(codigo), .dispense(dispense), .change(change), .change_valid(change_valid),
        .coin_reject(coin_reject), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: credit as an integer, a message as a count of display cycles left
    always @(posedge clk or negedge rst_n) begin
        int add;
        add = coin_1 + 2 * coin_2;
        e_dispense = 0; e_change = 0; e_cv = 0; e_rej = 0;
        if (!rst_n) begin
            m_credit = 0; m_left = 0;
        end else if (cancel) begin
            e_change = m_credit; e_cv = int'(m_credit > 0); e_rej = int'(add > 0);
            m_credit = 0; m_left = 0;
        end else if (m_left > 0) begin
            e_rej = int'(add > 0); m_left--;
        end else if (buy) begin
            e_rej = int'(add > 0); m_left = MSG;
            if (m_credit >= PRICE) begin
                e_dispense = 1; e_change = m_credit - PRICE; e_cv = int'(e_change > 0);
                m_credit = 0; m_msg = 4'h9;
            end else m_msg = 4'h8;
        end else if (add > 0) begin
            if (m_credit + add <= MAX_CREDIT) m_credit += add;
            else begin e_rej = 1; m_left = MSG; m_msg = 4'h6; end
        end
    end

    always @(negedge clk) begin
        chk("m_codigo", 8'(codigo), m_left > 0 ? 8'(m_msg) : 8'(m_credit));
        chk("m_busy", 8'(busy), 8'(m_left > 0));
        chk("m_dispense", 8'(dispense), 8'(e_dispense));
        chk("m_change", 8'(change), 8'(e_change));
        chk("m_change_valid", 8'(change_valid), 8'(e_cv));
        chk("m_coin_reject", 8'(coin_reject), 8'(e_rej));
    end

    task automatic cyc(input logic c1, input logic c2, input logic b, input logic cn);
        coin_1 = c1; coin_2 = c2; buy = b; cancel = cn;
        @(posedge clk); #1;
        coin_1 = 0; coin_2 = 0; buy = 0; cancel = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    initial begin
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_codigo", 8'(codigo), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        cyc(1, 0, 0, 0); chk("coin1", 8'(codigo), 8'd1);
        cyc(0, 1, 0, 0); chk("coin2", 8'(codigo), 8'd3);
        cyc(0, 0, 1, 0); chk("exact_disp", 8'(dispense), 8'd1);
        chk("exact_cv", 8'(change_valid), 8'd0); chk("exact_p", 8'(codigo), 8'd9);
        idle(3); chk("p_hold", 8'(codigo), 8'd9);
        idle(1); chk("p_end", 8'(codigo), 8'd0); chk("p_end_busy", 8'(busy), 8'd0);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); chk("credit5", 8'(codigo), 8'd5);
        cyc(0, 0, 1, 0); chk("chg_disp", 8'(dispense), 8'd1);
        chk("chg_val", 8'(change), 8'd2); chk("chg_cv", 8'(change_valid), 8'd1);
        chk("chg_p", 8'(codigo), 8'd9);
        idle(4); chk("chg_end", 8'(codigo), 8'd0);
        cyc(0, 1, 0, 0); cyc(0, 0, 1, 0);
        chk("insuf_n", 8'(codigo), 8'd8); chk("insuf_disp", 8'(dispense), 8'd0);
        idle(3); chk("n_hold", 8'(codigo), 8'd8);
        idle(1); chk("n_end", 8'(codigo), 8'd2);
        cyc(0, 1, 0, 0); chk("credit4", 8'(codigo), 8'd4);
        cyc(1, 1, 0, 0); chk("ovf_rej", 8'(coin_reject), 8'd1); chk("ovf_e", 8'(codigo), 8'd6);
        idle(4); chk("ovf_end", 8'(codigo), 8'd4);
        cyc(0, 0, 0, 1); chk("cancel_chg", 8'(change), 8'd4); chk("cancel_cv", 8'(change_valid), 8'd1);
        chk("cancel_code", 8'(codigo), 8'd0);
        cyc(1, 1, 0, 0); chk("pair3", 8'(codigo), 8'd3); chk("pair3_rej", 8'(coin_reject), 8'd0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 1); chk("prio_chg", 8'(change), 8'd4); chk("prio_cv", 8'(change_valid), 8'd1);
        chk("prio_rej", 8'(coin_reject), 8'd1); chk("prio_disp", 8'(dispense), 8'd0);
        chk("prio_code", 8'(codigo), 8'd0);
        cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 1, 0); idle(1);
        cyc(0, 0, 0, 1); chk("abort_p", 8'(codigo), 8'd0); chk("abort_busy", 8'(busy), 8'd0);
        chk("abort_cv", 8'(change_valid), 8'd0);
        cyc(1, 0, 0, 0); cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0); chk("msg_coin_rej", 8'(coin_reject), 8'd1); chk("msg_coin_code", 8'(codigo), 8'd8);
        idle(3); chk("msg_coin_end", 8'(codigo), 8'd1);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); chk("credit4b", 8'(codigo), 8'd4);
        cyc(1, 0, 0, 0); chk("max_ok", 8'(codigo), 8'd5); chk("max_ok_rej", 8'(coin_reject), 8'd0);
        cyc(1, 0, 0, 0); chk("max_rej", 8'(coin_reject), 8'd1); chk("max_e", 8'(codigo), 8'd6);
        idle(4); chk("max_end", 8'(codigo), 8'd5);
        cyc(0, 0, 0, 1); chk("cancel5", 8'(change), 8'd5);
        cyc(0, 1, 0, 0); cyc(0, 0, 1, 0);
        #2 rst_n = 0;
        #1 chk("mid_rst_code", 8'(codigo), 8'd0); chk("mid_rst_busy", 8'(busy), 8'd0);
        chk("mid_rst_cv", 8'(change_valid), 8'd0);
        @(posedge clk); #1 rst_n = 1;
        chk("post_rst", 8'(codigo), 8'd0);
        cyc(1, 0, 0, 0); chk("post_rst_coin", 8'(codigo), 8'd1);
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
